// File: rtl/msg_send_arbiter.sv
// Round-robin arbiter sharing one P2S byte serializer between NUM_SRC message senders.
// Define MSG_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration instead.
module msg_send_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int BUSY_WAIT = 8
) (
  input  logic                   Clock,
  input  logic                   Clear,
  input  logic [NUM_SRC-1:0]     Request,
  input  logic [NUM_SRC-1:0]     SenderReady,
  input  logic [NUM_SRC-1:0]     SenderLoad,
  input  logic [8*NUM_SRC-1:0]   SenderByte,
  input  logic                   P2S_Empty,
  output logic [NUM_SRC-1:0]     Send,
  output logic [NUM_SRC-1:0]     SenderEmpty,
  output logic [NUM_SRC-1:0]     Done,
  output logic [15:0]            SeqNumber,
  output logic                   P2SLoad,
  output logic [7:0]             P2SByte,
  output logic                   Busy,
  output logic                   Error
);

  // state     | meaning
  // IDLE      | no message in flight, arbitrating requests
  // START     | Send pulse to the granted sender
  // WAIT_BUSY | waiting for the sender to drop Ready (bounded by BUSY_WAIT)
  // WAIT_DONE | sender streaming bytes until Ready and serializer empty
  // FINISH    | Done (and Error if abandoned) pulse, pointer advance
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] FINISH    = 3'd4;

  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(BUSY_WAIT + 1);

  logic [2:0]    state, stateNext;
  logic [GW-1:0] grant, grantNext, pick;
  logic [CW-1:0] busyCnt, busyCntNext;
  logic          abandon, abandonNext;
  logic [15:0]   seqNext;

`ifdef MSG_ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (Request[i]) pick = GW'(i);
    end
  end
`else
  logic [GW-1:0] rrPtr;
  logic [GW-1:0] idx;
  logic          found;

  // First requester at or after the pointer, wrapping past the top index.
  always_comb begin
    pick  = rrPtr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = GW'((int'(rrPtr) + k) % NUM_SRC);
      if (!found && Request[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      rrPtr <= '0;
    end else if (state == FINISH) begin
      rrPtr <= (grant == GW'(NUM_SRC - 1)) ? '0 : grant + GW'(1);
    end
  end
`endif

  always_comb begin
    stateNext   = state;
    grantNext   = grant;
    busyCntNext = busyCnt;
    abandonNext = abandon;
    seqNext     = SeqNumber;
    case (state)
      IDLE: begin
        if (|Request) begin
          grantNext = pick;
          stateNext = START;
        end
      end
      START: begin
        busyCntNext = '0;
        abandonNext = 1'b0;
        stateNext   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!SenderReady[grant]) begin
          stateNext = WAIT_DONE;
        end else begin
          busyCntNext = busyCnt + CW'(1);
          if (busyCnt == CW'(BUSY_WAIT - 1)) begin
            abandonNext = 1'b1;
            stateNext   = FINISH;
          end
        end
      end
      WAIT_DONE: begin
        if (SenderReady[grant] && P2S_Empty) stateNext = FINISH;
      end
      FINISH: begin
        if (!abandon) seqNext = SeqNumber + 16'd1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state     <= IDLE;
      grant     <= '0;
      busyCnt   <= '0;
      abandon   <= 1'b0;
      SeqNumber <= 16'd0;
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      busyCnt   <= busyCntNext;
      abandon   <= abandonNext;
      SeqNumber <= seqNext;
    end
  end

  // Byte path is a zero-latency mux so the sender's LoadByte timing reaches the serializer untouched.
  always_comb begin
    Send        = '0;
    Done        = '0;
    SenderEmpty = '0;
    P2SLoad     = 1'b0;
    P2SByte     = 8'd0;
    Error       = 1'b0;
    Busy        = (state != IDLE);
    case (state)
      START: begin
        Send[grant]        = 1'b1;
        SenderEmpty[grant] = P2S_Empty;
      end
      WAIT_BUSY, WAIT_DONE: begin
        SenderEmpty[grant] = P2S_Empty;
        P2SLoad            = SenderLoad[grant];
        P2SByte            = SenderByte[8*grant +: 8];
      end
      FINISH: begin
        Done[grant] = 1'b1;
        Error       = abandon;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msg_send_arbiter.sv
// Self-checking bench for msg_send_arbiter: directed scenarios plus randomized messages
// checked against a grant/sequence-number model.
module tb_msg_send_arbiter;
  localparam int NS = 4;
  localparam int BW = 8;

  logic              Clock = 1'b0;
  logic              Clear;
  logic [NS-1:0]     Request, SenderReady, SenderLoad;
  logic [8*NS-1:0]   SenderByte;
  logic              P2S_Empty;
  logic [NS-1:0]     Send, SenderEmpty, Done;
  logic [15:0]       SeqNumber;
  logic              P2SLoad;
  logic [7:0]        P2SByte;
  logic              Busy, Error;

  int          tests  = 0;
  int          failed = 0;
  int          expPtr = 0;
  logic [15:0] expSeq = 16'd0;

  msg_send_arbiter #(.NUM_SRC(NS), .BUSY_WAIT(BW)) dut (
    .Clock(Clock), .Clear(Clear), .Request(Request), .SenderReady(SenderReady),
    .SenderLoad(SenderLoad), .SenderByte(SenderByte), .P2S_Empty(P2S_Empty),
    .Send(Send), .SenderEmpty(SenderEmpty), .Done(Done), .SeqNumber(SeqNumber),
    .P2SLoad(P2SLoad), .P2SByte(P2SByte), .Busy(Busy), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pickGrant(input logic [NS-1:0] req);
    logic [NS-1:0] r;
`ifdef MSG_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NS; i++) begin
      r = req >> i;
      if (r[0]) return i;
    end
`else
    for (int k = 0; k < NS; k++) begin
      r = req >> ((expPtr + k) % NS);
      if (r[0]) return (expPtr + k) % NS;
    end
`endif
    return 0;
  endfunction

  function automatic logic bitOf(input logic [NS-1:0] v, input int i);
    logic [NS-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [7:0] byteOf(input int i);
    logic [8*NS-1:0] t;
    t = SenderByte >> (8 * i);
    return t[7:0];
  endfunction

  task automatic driveRand();
    SenderLoad = NS'($urandom);
    SenderByte = $urandom;
    P2S_Empty  = 1'($urandom_range(0, 1));
  endtask

  task automatic idleCycle();
    @(posedge Clock); #1;
    Request = '0; SenderReady = '1; driveRand(); #1;
    chk("gap_busy", Busy, 0);
    chk("gap_seq", SeqNumber, expSeq);
    chk("gap_load", P2SLoad, 0);
  endtask

  task automatic runMsg(input logic [NS-1:0] req, input int dropDelay, input int nBytes,
                        input bit stuck, input bit holdReq, input int abortAt);
    int g, finK;
    logic [NS-1:0] oh;
    logic readyG;
    @(posedge Clock); #1;
    Request = req; SenderReady = '1; driveRand(); #1;
    chk("idle_busy", Busy, 0);
    chk("idle_seq", SeqNumber, expSeq);
    chk("idle_send", Send, 0);
    chk("idle_done", Done, 0);
    chk("idle_err", Error, 0);
    chk("idle_load", P2SLoad, 0);
    chk("idle_byte", P2SByte, 0);
    chk("idle_empty", SenderEmpty, 0);
    g  = pickGrant(req);
    oh = NS'(1) << g;

    @(posedge Clock); #1;
    SenderReady = '1; driveRand(); #1;
    chk("start_send", Send, oh);
    chk("start_busy", Busy, 1);
    chk("start_seq", SeqNumber, expSeq);
    chk("start_done", Done, 0);
    chk("start_load", P2SLoad, 0);
    chk("start_byte", P2SByte, 0);
    chk("start_empty", SenderEmpty, P2S_Empty ? oh : NS'(0));

    finK = stuck ? BW + 1 : dropDelay + nBytes + 3;
    for (int k = 1; k < finK; k++) begin
      @(posedge Clock); #1;
      driveRand();
      if (!holdReq && k == 1) Request = Request & ~oh;
      if (stuck || k < dropDelay) readyG = 1'b1;
      else if (k == dropDelay) readyG = 1'b0;
      else if (k == finK - 1) begin
        readyG = 1'b1;
        P2S_Empty = 1'b1;
      end else begin
        readyG = 1'($urandom_range(0, 1));
        if (readyG) P2S_Empty = 1'b0;
      end
      SenderReady = readyG ? '1 : ~oh;
      #1;
      chk("wait_send", Send, 0);
      chk("wait_done", Done, 0);
      chk("wait_err", Error, 0);
      chk("wait_busy", Busy, 1);
      chk("wait_seq", SeqNumber, expSeq);
      chk("wait_load", P2SLoad, bitOf(SenderLoad, g));
      chk("wait_byte", P2SByte, byteOf(g));
      chk("wait_empty", SenderEmpty, P2S_Empty ? oh : NS'(0));
      if (k == abortAt) begin
        Clear = 1'b1; #1;
        chk("abort_busy", Busy, 0);
        chk("abort_seq", SeqNumber, 0);
        chk("abort_done", Done, 0);
        chk("abort_err", Error, 0);
        chk("abort_send", Send, 0);
        chk("abort_load", P2SLoad, 0);
        chk("abort_empty", SenderEmpty, 0);
        expPtr = 0;
        expSeq = 16'd0;
        return;
      end
    end

    @(posedge Clock); #1;
    SenderReady = '1; driveRand(); #1;
    chk("fin_done", Done, oh);
    chk("fin_err", Error, stuck);
    chk("fin_send", Send, 0);
    chk("fin_busy", Busy, 1);
    chk("fin_load", P2SLoad, 0);
    chk("fin_byte", P2SByte, 0);
    chk("fin_empty", SenderEmpty, 0);
    chk("fin_seq", SeqNumber, expSeq);
    if (!stuck) expSeq = expSeq + 16'd1;
    expPtr = (g + 1) % NS;
  endtask

  initial begin
    Clear = 1'b1; Request = '0; SenderReady = '1; SenderLoad = '1;
    SenderByte = '1; P2S_Empty = 1'b1;
    #12;
    chk("rst_busy", Busy, 0);
    chk("rst_seq", SeqNumber, 0);
    chk("rst_send", Send, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Error, 0);
    chk("rst_load", P2SLoad, 0);
    chk("rst_byte", P2SByte, 0);
    chk("rst_empty", SenderEmpty, 0);
    @(posedge Clock); #1;
    Clear = 1'b0;

    runMsg(4'b0001, 2, 10, 1'b0, 1'b0, 0);

    for (int i = 0; i < 4; i++)
      runMsg(4'b1111, $urandom_range(1, BW - 1), $urandom_range(0, 5), 1'b0, 1'b1, 0);

    runMsg(4'b0100, 1, 0, 1'b1, 1'b0, 0);
    runMsg(4'b0100, 2, 3, 1'b0, 1'b0, 0);

    for (int i = 0; i < 4; i++)
      runMsg(4'b1010, $urandom_range(1, BW - 1), $urandom_range(0, 4), 1'b0, 1'b1, 0);

    @(posedge Clock); #1;
    Request = '0;
    force dut.SeqNumber = 16'hFFFF;
    repeat (2) @(posedge Clock);
    #1;
    release dut.SeqNumber;
    #1;
    chk("wrap_preload", SeqNumber, 16'hFFFF);
    expSeq = 16'hFFFF;
    runMsg(4'b0010, 3, 2, 1'b0, 1'b0, 0);
    idleCycle();
    chk("wrap_zero", SeqNumber, 16'h0000);

    runMsg(4'b0010, 2, 3, 1'b0, 1'b0, 4);
    repeat (2) begin
      @(posedge Clock); #1;
      chk("clear_busy", Busy, 0);
      chk("clear_done", Done, 0);
      chk("clear_err", Error, 0);
      chk("clear_seq", SeqNumber, 0);
    end
    Request = '0;
    Clear = 1'b0;
    runMsg(4'b1001, 2, 2, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycle();
      runMsg(NS'($urandom_range(1, 15)), $urandom_range(1, BW - 1), $urandom_range(0, 6),
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 0);
    end
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
